// File: rtl/lm_sm_sequencer_if.sv
// Handshake and instruction bus between pipe1, the LM/SM sequencer and decode.
interface lm_sm_sequencer_if;
    logic        flush;
    logic [15:0] ir_in;
    logic        valid_in;
    logic        stall_in;
    logic        ready_out;
    logic [15:0] ir_out;
    logic        valid_out;
    logic [15:0] offset_out;
    logic        first_out;
    logic        last_out;

    // The sequencer itself.
    modport slave (
        input  flush, ir_in, valid_in, stall_in,
        output ready_out, ir_out, valid_out, offset_out, first_out, last_out
    );

    // The environment around it: pipe1 and decode.
    modport master (
        output flush, ir_in, valid_in, stall_in,
        input  ready_out, ir_out, valid_out, offset_out, first_out, last_out
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM instructions into one single-register micro-op per set list
// bit, ascending order, one per cycle; all other instructions pass through.
module lm_sm_sequencer #(
    parameter logic [3:0] LM_OPCODE = 4'b0110,
    parameter logic [3:0] SM_OPCODE = 4'b0111,
    parameter int         LIST_W    = 8
) (
    input  logic clk,
    input  logic reset,
    lm_sm_sequencer_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_reg, state_next;
    logic [LIST_W-1:0]   rem_mask_reg, rem_mask_next;
    logic [15:0]         base_ir_reg, base_ir_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [15:0]         ir_out_reg, ir_out_next;
    logic                valid_out_reg, valid_out_next;
    logic [15:0]         offset_out_reg, offset_out_next;
    logic                first_out_reg, first_out_next;
    logic                last_out_reg, last_out_next;

    logic [LIST_W-1:0]   pick_src;
    logic [LIST_W-1:0]   pick_low;
    logic [LIST_W-1:0]   pick_rest;
    logic                is_multi;

    // One shared lowest-set-bit picker: fed from ir_in when idle, rem_mask when busy.
    assign pick_src  = (state_reg == BUSY) ? rem_mask_reg : bus.ir_in[LIST_W-1:0];
    assign pick_rest = pick_src & ~pick_low;

    generate
        for (genvar gi = 0; gi < LIST_W; gi++) begin : g_pick
            if (gi == 0) begin : g_lsb
                assign pick_low[gi] = pick_src[gi];
            end else begin : g_upper
                assign pick_low[gi] = pick_src[gi] & ~(|pick_src[gi-1:0]);
            end
        end
    endgenerate

    assign is_multi = (bus.ir_in[15:12] == LM_OPCODE) || (bus.ir_in[15:12] == SM_OPCODE);
    assign bus.ready_out = !bus.stall_in && !bus.flush && (state_reg == IDLE);

    always_comb begin
        state_next      = state_reg;
        rem_mask_next   = rem_mask_reg;
        base_ir_next    = base_ir_reg;
        cnt_next        = cnt_reg;
        ir_out_next     = ir_out_reg;
        valid_out_next  = valid_out_reg;
        offset_out_next = offset_out_reg;
        first_out_next  = first_out_reg;
        last_out_next   = last_out_reg;

        if (bus.flush) begin
            state_next      = IDLE;
            rem_mask_next   = '0;
            cnt_next        = '0;
            ir_out_next     = '0;
            valid_out_next  = 1'b0;
            offset_out_next = '0;
            first_out_next  = 1'b0;
            last_out_next   = 1'b0;
        end else if (!bus.stall_in) begin
            case (state_reg)
                IDLE: begin
                    valid_out_next = 1'b0;
                    if (bus.valid_in) begin
                        if (!is_multi) begin
                            ir_out_next     = bus.ir_in;
                            valid_out_next  = 1'b1;
                            offset_out_next = '0;
                            first_out_next  = 1'b1;
                            last_out_next   = 1'b1;
                        end else if (|bus.ir_in[LIST_W-1:0]) begin
                            // Bit 8 is forced low so decode treats the micro-op as a plain transfer.
                            ir_out_next     = {bus.ir_in[15:LIST_W+1], 1'b0, pick_low};
                            valid_out_next  = 1'b1;
                            offset_out_next = '0;
                            first_out_next  = 1'b1;
                            last_out_next   = (pick_rest == '0);
                            rem_mask_next   = pick_rest;
                            base_ir_next    = bus.ir_in;
                            cnt_next        = 4'd1;
                            state_next      = (pick_rest == '0) ? IDLE : BUSY;
                        end
                    end
                end
                BUSY: begin
                    ir_out_next     = {base_ir_reg[15:LIST_W+1], 1'b0, pick_low};
                    valid_out_next  = 1'b1;
                    offset_out_next = {12'd0, cnt_reg};
                    first_out_next  = 1'b0;
                    last_out_next   = (pick_rest == '0);
                    rem_mask_next   = pick_rest;
                    cnt_next        = cnt_reg + 4'd1;
                    state_next      = (pick_rest == '0) ? IDLE : BUSY;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            rem_mask_reg   <= '0;
            base_ir_reg    <= '0;
            cnt_reg        <= '0;
            ir_out_reg     <= '0;
            valid_out_reg  <= 1'b0;
            offset_out_reg <= '0;
            first_out_reg  <= 1'b0;
            last_out_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rem_mask_reg   <= rem_mask_next;
            base_ir_reg    <= base_ir_next;
            cnt_reg        <= cnt_next;
            ir_out_reg     <= ir_out_next;
            valid_out_reg  <= valid_out_next;
            offset_out_reg <= offset_out_next;
            first_out_reg  <= first_out_next;
            last_out_reg   <= last_out_next;
        end
    end

    assign bus.ir_out     = ir_out_reg;
    assign bus.valid_out  = valid_out_reg;
    assign bus.offset_out = offset_out_reg;
    assign bus.first_out  = first_out_reg;
    assign bus.last_out   = last_out_reg;
endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Sits between pipe1 (fetch/IR register) and decode.
- Expands each LM/SM instruction into one micro-instruction per set bit of its 8-bit register list, emitted one per cycle. Each micro-instruction's list field is one-hot, so decode's priority pick selects exactly that register.
- Provides a per-micro-op address offset for execute, and back-pressures fetch while a sequence is in flight.
- All other instructions pass through with one cycle of latency.

Parameters:
- LM_OPCODE, 4'b0110, opcode expanded as load-multiple.
- SM_OPCODE, 4'b0111, opcode expanded as store-multiple.
- LIST_W, 8, register-list width (IR[7:0]); one bit per register R0..R7.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  squash in-flight sequence (branch/R7 redirect).
- ir_in  input  16  instruction from pipe1.
- valid_in  input  1  ir_in holds a real instruction.
- stall_in  input  1  downstream (decode/pipe2) cannot accept this cycle.
- ready_out  output  1  combinational, to pipe1; ir_in consumed this edge.
- ir_out  output  16  registered instruction or micro-instruction to decode.
- valid_out  output  1  registered; ir_out valid.
- offset_out  output  16  registered zero-extended count of prior transfers in the sequence; execute forms RA+offset_out.
- first_out  output  1  registered; first micro-op of an instruction.
- last_out  output  1  registered; final micro-op of an instruction. Pass-through instructions assert first_out and last_out together.

Behaviour:
- States: IDLE, BUSY.
- Internal registers:
  - rem_mask[7:0], the bits still to issue.
  - base_ir[15:0].
  - cnt[3:0], the count of micro-ops issued so far.
- ready_out = !stall_in && !flush && state==IDLE.
- Priority order: reset > flush > stall_in > normal operation.
- Reset:
  - state=IDLE, rem_mask=0, cnt=0.
  - valid_out=0, ir_out=0, offset_out=0, first_out=0, last_out=0.
  - Reset mid-sequence abandons the sequence; no further micro-ops are issued.
- flush (not reset): same clearing as reset on the next edge; ir_in is not consumed.
- stall_in=1: every register holds, including output registers and state.
- IDLE, not stalled:
  - valid_in=0 → valid_out=0; other outputs don't-care.
  - Opcode not LM/SM → ir_out=ir_in, valid_out=1, offset_out=0, first_out=1, last_out=1.
  - LM/SM with IR[7:0]==0:
    - Instruction is dropped: valid_out=0, ready_out stays 1.
    - No register or memory effect.
  - LM/SM with IR[7:0]!=0:
    - Let b = index of the lowest set bit.
    - ir_out = {IR[15:9], 1'b0, onehot(b)}; IR[8] is forced to 0.
    - valid_out=1, offset_out=0, first_out=1.
    - rem_mask = IR[7:0] with bit b cleared; base_ir=ir_in; cnt=1.
    - If rem_mask==0: last_out=1 and stay in IDLE. Otherwise last_out=0 and go to BUSY.
- BUSY, not stalled:
  - Let b = lowest set bit of rem_mask.
  - ir_out = {base_ir[15:9], 1'b0, onehot(b)}, valid_out=1.
  - offset_out = cnt, first_out=0; clear bit b of rem_mask; cnt=cnt+1.
  - If the cleared rem_mask==0: last_out=1 and go to IDLE. Otherwise last_out=0 and stay in BUSY.
  - ready_out=0 throughout BUSY.
- Latency and throughput:
  - Pass-through: 1 cycle.
  - An N-register list occupies N consecutive unstalled cycles.
  - Fetch is held for N-1 cycles after acceptance.
- Registers are issued in ascending order. Bit 7 (R7) is legal and is issued last.
- cnt maximum is 8; offset_out maximum is 7. No wrap is possible.

Test Plan:
- LM, ir_in=0x64A5 (RA=R2, list 10100101), no stall → over 4 cycles: ir_out = 0x6401/0x6404/0x6420/0x6480, offset_out = 0/1/2/3, first_out on the first only, last_out on the fourth only; ready_out=0 for exactly 3 cycles after acceptance.
- SM, ir_in=0x7E80 (R7 only) → single micro-op 0x7E80, first_out=last_out=1, offset_out=0; state stays IDLE and ready_out stays 1.
- ADD 0x0298 followed by LM list 0x00 → 0x0298 emitted with first_out=last_out=1, offset_out=0; next cycle valid_out=0, and the next instruction is accepted immediately.
- LM list 0xFF with stall_in held for 2 cycles during the third micro-op → outputs frozen at 0x6?04/offset 2 during the stall; sequence resumes and completes offsets 3..7 with no skip or duplicate; 8 valid micro-ops total.
- flush asserted after the second micro-op of list 0x0F → next edge valid_out=0, state IDLE, ready_out=1; no further micro-ops.
- reset asserted mid-sequence together with stall_in → all outputs zero on the next edge; reset overrides the stall.
